demux_1to4_reg: RTL and testbench

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

---
 rtl/demux_1to4_reg_pkg.sv | 17 +
 rtl/demux_slot.sv | 50 +++++
 rtl/demux_1to4_reg.sv | 67 ++++++
 tb/tb_demux_1to4_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to4_reg_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer:
// the default payload width, the sel encodings and the slot states.
package demux_1to4_reg_pkg;

  localparam int DEFAULT_SIZE = 16;

  localparam logic [1:0] SEL_OUT1 = 2'b00;
  localparam logic [1:0] SEL_OUT2 = 2'b01;
  localparam logic [1:0] SEL_OUT3 = 2'b10;
  localparam logic [1:0] SEL_OUT4 = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux_1to4_reg_pkg

// File: rtl/demux_slot.sv
// One-entry output slot: a payload register plus a FULL flag.
// The parent only pushes when the slot is empty or is popped in the same
// cycle, so a push always wins and leaves the slot FULL with the new data.
module demux_slot
  import demux_1to4_reg_pkg::*;
#(
  parameter int size = DEFAULT_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [size:1] in_data,
  output logic          full,
  output logic [size:1] data
);

  slot_state_e   state_q, state_d;
  logic [size:1] data_q, data_d;

  // Next-state and next-payload selection for the slot.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    data_d  = data_q;
    if (push) begin
      state_d = SLOT_FULL;
      data_d  = in_data;
    end else if (pop) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot registers with synchronous reset that overrides any push or pop.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (rst) begin
      state_q <= SLOT_EMPTY;
      // NOTE: the payload is reset too, because the outputs must read zero after reset.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign full = (state_q == SLOT_FULL);
  assign data = data_q;

endmodule : demux_slot

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry slot per destination.
// An input beat is steered by sel into its slot; each slot drains
// independently through its own valid/ready pair.
module demux_1to4_reg
  import demux_1to4_reg_pkg::*;
#(
  parameter int size = DEFAULT_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [size:1] in_data,
  input  logic          in_valid,
  input  logic [1:0]    sel,
  output logic          in_ready,
  output logic [size:1] out1,
  output logic [size:1] out2,
  output logic [size:1] out3,
  output logic [size:1] out4,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic          busy
);

  logic [3:0]    sel_onehot;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [3:0]    full;
  logic [size:1] slot_data [4];

  // Decode sel into a one-hot destination vector.
  always_comb begin
    sel_onehot = '0;
    case (sel)
      SEL_OUT1: sel_onehot[0] = 1'b1;
      SEL_OUT2: sel_onehot[1] = 1'b1;
      SEL_OUT3: sel_onehot[2] = 1'b1;
      default:  sel_onehot[3] = 1'b1;
    endcase
  end

  // A slot can take a beat if it is empty or is being drained this cycle.
  assign pop      = full & out_ready;
  assign in_ready = ~full[sel] | pop[sel];
  assign push     = sel_onehot & {4{in_valid & in_ready}};

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .size(size)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .push   (push[k]),
      .pop    (pop[k]),
      .in_data(in_data),
      .full   (full[k]),
      .data   (slot_data[k])
    );
  end

  assign out1      = slot_data[0];
  assign out2      = slot_data[1];
  assign out3      = slot_data[2];
  assign out4      = slot_data[3];
  assign out_valid = full;
  assign busy      = |full;

endmodule : demux_1to4_reg

// File: tb/tb_demux_1to4_reg.sv
// Self-checking bench for demux_1to4_reg: directed scenarios followed by
// random traffic, all checked against per-output scoreboard queues.
module tb_demux_1to4_reg;

  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE:1]   in_data;
  logic            in_valid;
  logic [1:0]      sel;
  logic            in_ready;
  logic [SIZE:1]   out1, out2, out3, out4;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: one queue per destination, holding beats not yet popped.
  logic [15:0] sb1 [$];
  logic [15:0] sb2 [$];
  logic [15:0] sb3 [$];
  logic [15:0] sb4 [$];

  always #5 clk = ~clk;

  demux_1to4_reg #(.size(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sel      (sel),
    .in_ready (in_ready),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0: return sb1.size();
      1: return sb2.size();
      2: return sb3.size();
      default: return sb4.size();
    endcase
  endfunction

  function automatic logic [15:0] sb_front(input int k);
    case (k)
      0: return sb1[0];
      1: return sb2[0];
      2: return sb3[0];
      default: return sb4[0];
    endcase
  endfunction

  task automatic sb_pop(input int k);
    case (k)
      0: void'(sb1.pop_front());
      1: void'(sb2.pop_front());
      2: void'(sb3.pop_front());
      default: void'(sb4.pop_front());
    endcase
  endtask

  task automatic sb_push(input int k, input logic [15:0] d);
    case (k)
      0: sb1.push_back(d);
      1: sb2.push_back(d);
      2: sb3.push_back(d);
      default: sb4.push_back(d);
    endcase
  endtask

  function automatic logic [15:0] dut_out(input int k);
    case (k)
      0: return out1;
      1: return out2;
      2: return out3;
      default: return out4;
    endcase
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (sb_size(k) > 0);
    return v;
  endfunction

  // One clock cycle: drive inputs just after an edge, check the
  // combinational ready and held payloads, clock, then check valid/busy.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] r, input logic do_rst, output logic accepted);
    logic       exp_rdy;
    logic [3:0] pops;
    rst       = do_rst;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = (sb_size(int'(s)) == 0) || r[s];
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    for (int k = 0; k < 4; k++) begin
      pops[k] = r[k] && (sb_size(k) > 0);
      if (sb_size(k) > 0) check($sformatf("out%0d_data", k + 1), {16'd0, dut_out(k)}, {16'd0, sb_front(k)});
    end
    accepted = v && exp_rdy && !do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      sb1.delete(); sb2.delete(); sb3.delete(); sb4.delete();
    end else begin
      for (int k = 0; k < 4; k++) if (pops[k]) sb_pop(k);
      if (accepted) sb_push(int'(s), d);
    end
    check("out_valid", {28'd0, out_valid}, {28'd0, exp_valid()});
    check("busy", {31'd0, busy}, {31'd0, |exp_valid()});
  endtask

  initial begin
    logic acc;
    int   pushes;
    int   cycles;

    rst = 1'b1; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {out1 | out2, out3 | out4}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Push A5A5 into slot 3.
    cycle(1'b1, 2'b10, 16'hA5A5, 4'b0000, 1'b0, acc);
    in_valid = 1'b0;
    check("push3_out3", {16'd0, out3}, 32'h0000_A5A5);
    check("push3_valid", {28'd0, out_valid}, 32'h4);
    check("push3_others", {out1 | out2, out4}, 32'd0);

    // Slot 3 stalled: new beat is refused, then same-cycle push/pop.
    cycle(1'b1, 2'b10, 16'h1234, 4'b0000, 1'b0, acc);
    check("stall_refused", {31'd0, acc}, 32'd0);
    check("stall_out3_hold", {16'd0, out3}, 32'h0000_A5A5);
    cycle(1'b1, 2'b10, 16'h1234, 4'b0100, 1'b0, acc);
    check("pushpop_out3", {16'd0, out3}, 32'h0000_1234);
    check("pushpop_valid3", {31'd0, out_valid[2]}, 32'd1);

    // Slot 1 stalled, push to slot 2 still goes through.
    cycle(1'b1, 2'b00, 16'h1111, 4'b0000, 1'b0, acc);
    cycle(1'b1, 2'b01, 16'h00FF, 4'b0000, 1'b0, acc);
    check("push2_accepted", {31'd0, acc}, 32'd1);
    check("push2_out2", {16'd0, out2}, 32'h0000_00FF);
    check("push2_out1_hold", {16'd0, out1}, 32'h0000_1111);

    // Fill slot 4, then drain all four at once.
    cycle(1'b1, 2'b11, 16'hBEEF, 4'b0000, 1'b0, acc);
    check("all_full", {28'd0, out_valid}, 32'hF);
    cycle(1'b0, 2'b00, 16'hDEAD, 4'b1111, 1'b0, acc);
    check("drain_all_valid", {28'd0, out_valid}, 32'd0);
    check("drain_all_busy", {31'd0, busy}, 32'd0);
    check("empty_out1_retained", {16'd0, out1}, 32'h0000_1111);

    // Reset during a push to a full slot 4 discards everything.
    cycle(1'b1, 2'b11, 16'hBEEF, 4'b0000, 1'b0, acc);
    cycle(1'b1, 2'b11, 16'h5555, 4'b1000, 1'b1, acc);
    check("rst_push_valid", {28'd0, out_valid}, 32'd0);
    check("rst_push_out4", {16'd0, out4}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = '0;
    #1;
    check("rst_drop_in_ready", {31'd0, in_ready}, 32'd1);

    // Random traffic until 1000 beats have been accepted.
    pushes = 0;
    cycles = 0;
    while (pushes < 1000 && cycles < 20000) begin
      cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 16'($urandom),
            4'($urandom), 1'b0, acc);
      if (acc) pushes++;
      cycles++;
    end
    check("random_beats_done", pushes, 32'd1000);

    // Drain and confirm nothing is left or duplicated.
    repeat (4) cycle(1'b0, 2'b00, 16'h0000, 4'b1111, 1'b0, acc);
    check("final_sb_empty", sb1.size() + sb2.size() + sb3.size() + sb4.size(), 32'd0);
    check("final_out_valid", {28'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_1to4_reg
